// File: rtl/branch_pkg.sv
// Shared types for the branch resolve controller: FSM states and in-flight prediction entry.
package branch_pkg;
  localparam int PC_W = 32;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } ctrl_state_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            taken;
    logic [PC_W-1:0] target;
  } pred_entry_t;
endpackage

// File: rtl/branch_inflight_fifo.sv
// In-order prediction FIFO; head is combinational, push/pop take effect at the next edge.
// Caller guarantees no push when full without a pop and no pop when empty; clear wins over push.
module branch_inflight_fifo
  import branch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  pred_entry_t              push_dat,
  output pred_entry_t              head_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  pred_entry_t        mem_q [DEPTH];
  pred_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;
endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolve controller: checks predictions in order, drives PHT update, flush and redirect one cycle after resolve.
// Fetch is backpressured via pred_ready when the queue is full or during the post-flush recovery window.
module branch_resolve_ctrl
  import branch_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int IDX_W       = 6,
  parameter int RECOVER_CYC = 2,
  parameter int CNT_W       = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pred_valid,
  output logic                     pred_ready,
  input  logic [PC_W-1:0]          pred_pc,
  input  logic                     pred_taken,
  input  logic [PC_W-1:0]          pred_target,
  input  logic                     res_valid,
  input  logic                     res_taken,
  input  logic [PC_W-1:0]          res_target,
  output logic                     flush,
  output logic [PC_W-1:0]          redirect_pc,
  output logic                     upd_valid,
  output logic [IDX_W-1:0]         upd_index,
  output logic                     upd_taken,
  output logic                     res_error,
  output logic [$clog2(DEPTH):0]   inflight_count,
  output logic [CNT_W-1:0]         branch_count,
  output logic [CNT_W-1:0]         mispred_count
);
  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int RC_W = $clog2(RECOVER_CYC + 1);

  ctrl_state_t       state_q, state_d;
  logic [RC_W-1:0]   rcnt_q, rcnt_d;
  logic              flush_q, flush_d;
  logic [PC_W-1:0]   redirect_pc_q, redirect_pc_d;
  logic              upd_valid_q, upd_valid_d;
  logic [IDX_W-1:0]  upd_index_q, upd_index_d;
  logic              upd_taken_q, upd_taken_d;
  logic              res_error_q, res_error_d;
  logic [CNT_W-1:0]  branch_count_q, branch_count_d;
  logic [CNT_W-1:0]  mispred_count_q, mispred_count_d;

  pred_entry_t       head;
  pred_entry_t       push_dat;
  logic [CW-1:0]     fifo_count;
  logic              push, pop, clear, mispred;
  logic [PC_W-1:0]   correct_pc;

  branch_inflight_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .clear    (clear),
    .push_dat (push_dat),
    .head_dat (head),
    .count    (fifo_count)
  );

  always_comb begin
    push_dat   = '{pc: pred_pc, taken: pred_taken, target: pred_target};
    pop        = (state_q == RUN) && res_valid && (fifo_count != '0);
    pred_ready = (state_q == RUN) && ((fifo_count < CW'(DEPTH)) || pop);
    push       = pred_valid && pred_ready;
    mispred    = (head.taken != res_taken) ||
                 (head.taken && res_taken && (head.target != res_target));
    // A mispredict squashes everything younger, including a same-cycle push.
    clear      = pop && mispred;
    correct_pc = res_taken ? res_target : head.pc + PC_W'(4);
  end

  always_comb begin
    state_d         = state_q;
    rcnt_d          = rcnt_q;
    flush_d         = 1'b0;
    redirect_pc_d   = redirect_pc_q;
    upd_valid_d     = 1'b0;
    upd_index_d     = upd_index_q;
    upd_taken_d     = upd_taken_q;
    res_error_d     = 1'b0;
    branch_count_d  = branch_count_q;
    mispred_count_d = mispred_count_q;
    case (state_q)
      RUN: begin
        if (res_valid && !pop) begin
          res_error_d = 1'b1;
        end
        if (pop) begin
          upd_valid_d    = 1'b1;
          upd_index_d    = head.pc[IDX_W+1:2];
          upd_taken_d    = res_taken;
          branch_count_d = (branch_count_q == '1) ? branch_count_q : branch_count_q + CNT_W'(1);
          if (mispred) begin
            flush_d         = 1'b1;
            redirect_pc_d   = correct_pc;
            mispred_count_d = (mispred_count_q == '1) ? mispred_count_q
                                                      : mispred_count_q + CNT_W'(1);
            state_d         = RECOVER;
            rcnt_d          = RC_W'(RECOVER_CYC);
          end
        end
      end
      RECOVER: begin
        res_error_d = res_valid;
        if (rcnt_q <= RC_W'(1)) begin
          state_d = RUN;
          rcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q - RC_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= RUN;
      rcnt_q          <= '0;
      flush_q         <= 1'b0;
      redirect_pc_q   <= '0;
      upd_valid_q     <= 1'b0;
      upd_index_q     <= '0;
      upd_taken_q     <= 1'b0;
      res_error_q     <= 1'b0;
      branch_count_q  <= '0;
      mispred_count_q <= '0;
    end else begin
      state_q         <= state_d;
      rcnt_q          <= rcnt_d;
      flush_q         <= flush_d;
      redirect_pc_q   <= redirect_pc_d;
      upd_valid_q     <= upd_valid_d;
      upd_index_q     <= upd_index_d;
      upd_taken_q     <= upd_taken_d;
      res_error_q     <= res_error_d;
      branch_count_q  <= branch_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign flush          = flush_q;
  assign redirect_pc    = redirect_pc_q;
  assign upd_valid      = upd_valid_q;
  assign upd_index      = upd_index_q;
  assign upd_taken      = upd_taken_q;
  assign res_error      = res_error_q;
  assign inflight_count = fifo_count;
  assign branch_count   = branch_count_q;
  assign mispred_count  = mispred_count_q;
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed and random checks of branch_resolve_ctrl against a queue-based reference model.
module tb_branch_resolve_ctrl;
  localparam int DEPTH       = 4;
  localparam int IDX_W       = 6;
  localparam int RECOVER_CYC = 2;
  localparam int CNT_W       = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              pred_valid, pred_taken, res_valid, res_taken;
  logic [31:0]       pred_pc, pred_target, res_target;
  logic              pred_ready, flush, upd_valid, upd_taken, res_error;
  logic [31:0]       redirect_pc;
  logic [IDX_W-1:0]  upd_index;
  logic [$clog2(DEPTH):0] inflight_count;
  logic [CNT_W-1:0]  branch_count, mispred_count;

  branch_resolve_ctrl #(
    .DEPTH(DEPTH), .IDX_W(IDX_W), .RECOVER_CYC(RECOVER_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_pc(pred_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .flush(flush), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
    .res_error(res_error), .inflight_count(inflight_count),
    .branch_count(branch_count), .mispred_count(mispred_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } ent_t;

  int          errors = 0;
  int          checks = 0;
  ent_t        mq[$];
  int          rec;
  logic        e_flush, e_upd, e_utaken, e_err;
  logic [31:0] e_redir;
  logic [IDX_W-1:0] e_uidx;
  longint      e_bc, e_mc;
  localparam longint CMAX = (64'd1 << CNT_W) - 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    chk("flush", 64'(flush), 64'(e_flush));
    chk("upd_valid", 64'(upd_valid), 64'(e_upd));
    chk("res_error", 64'(res_error), 64'(e_err));
    chk("inflight_count", 64'(inflight_count), 64'(mq.size()));
    chk("branch_count", 64'(branch_count), 64'(e_bc));
    chk("mispred_count", 64'(mispred_count), 64'(e_mc));
    if (e_flush) chk("redirect_pc", 64'(redirect_pc), 64'(e_redir));
    if (e_upd) begin
      chk("upd_index", 64'(upd_index), 64'(e_uidx));
      chk("upd_taken", 64'(upd_taken), 64'(e_utaken));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; pred_valid = 1'b0; res_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    mq.delete(); rec = 0;
    e_flush = 0; e_upd = 0; e_utaken = 0; e_err = 0; e_bc = 0; e_mc = 0;
    check_outs();
    chk("rst_redirect_pc", 64'(redirect_pc), 64'h0);
    chk("rst_upd_index", 64'(upd_index), 64'h0);
    chk("rst_upd_taken", 64'(upd_taken), 64'h0);
    #1 chk("rst_pred_ready", 64'(pred_ready), 64'h1);
  endtask

  // One clock: drive inputs, check pred_ready, advance the model, check registered outputs.
  task automatic cycle(input logic pv, input logic [31:0] ppc, input logic pt, input logic [31:0] ptg,
                       input logic rv, input logic rt, input logic [31:0] rtg);
    logic exp_rdy, push_ok, mis;
    ent_t h;
    pred_valid = pv; pred_pc = ppc; pred_taken = pt; pred_target = ptg;
    res_valid = rv; res_taken = rt; res_target = rtg;
    #1;
    exp_rdy = (rec == 0) && ((mq.size() < DEPTH) || (rv && mq.size() > 0));
    chk("pred_ready", 64'(pred_ready), 64'(exp_rdy));
    push_ok = pv && exp_rdy;
    mis = 0; e_flush = 0; e_upd = 0; e_err = 0;
    if (rec > 0) begin
      e_err = rv;
      rec--;
    end else if (rv) begin
      if (mq.size() == 0) e_err = 1;
      else begin
        h = mq.pop_front();
        e_upd = 1;
        e_uidx = IDX_W'(h.pc >> 2);
        e_utaken = rt;
        if (e_bc < CMAX) e_bc++;
        mis = (h.taken != rt) || (h.taken && rt && h.target != rtg);
        if (mis) begin
          e_flush = 1;
          e_redir = rt ? rtg : h.pc + 32'd4;
          if (e_mc < CMAX) e_mc++;
          rec = RECOVER_CYC;
        end
      end
    end
    if (mis) mq.delete();
    else if (push_ok) mq.push_back('{pc: ppc, taken: pt, target: ptg});
    @(posedge clk); #1;
    pred_valid = 1'b0; res_valid = 1'b0;
    check_outs();
  endtask

  task automatic push(input logic [31:0] pc, input logic t, input logic [31:0] tg);
    cycle(1'b1, pc, t, tg, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic resolve(input logic t, input logic [31:0] tg);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, t, tg);
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    pred_pc = 0; pred_taken = 0; pred_target = 0; res_taken = 0; res_target = 0;
    do_reset();

    // Correct prediction
    push(32'h100, 1'b1, 32'h200);
    resolve(1'b1, 32'h200);
    chk("ok_upd_index", 64'(upd_index), 64'h00);
    chk("ok_upd_taken", 64'(upd_taken), 64'h1);
    chk("ok_flush", 64'(flush), 64'h0);
    chk("ok_branch_count", 64'(branch_count), 64'h1);

    // Direction mispredict, then two held cycles
    push(32'h1004, 1'b1, 32'h2000);
    resolve(1'b0, 32'h0);
    chk("dir_flush", 64'(flush), 64'h1);
    chk("dir_redirect", 64'(redirect_pc), 64'h1008);
    chk("dir_mispred_count", 64'(mispred_count), 64'h1);
    chk("dir_count", 64'(inflight_count), 64'h0);
    cycle(1'b1, 32'h5000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 32'h5000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("dir_ready_after", 64'(pred_ready), 64'h1);

    // Target mispredict
    push(32'h2000, 1'b1, 32'h300);
    resolve(1'b1, 32'h340);
    chk("tgt_flush", 64'(flush), 64'h1);
    chk("tgt_redirect", 64'(redirect_pc), 64'h340);
    chk("tgt_upd_taken", 64'(upd_taken), 64'h1);
    idle(); idle();

    // Full queue, push+pop at full, FIFO order
    for (int i = 0; i < DEPTH; i++) push(32'h10 + 32'(4 * i), 1'b0, 32'h0);
    chk("full_count", 64'(inflight_count), 64'h4);
    cycle(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 32'h20, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("full_pushpop_count", 64'(inflight_count), 64'h4);
    chk("full_first_idx", 64'(upd_index), 64'h04);
    for (int i = 0; i < DEPTH; i++) begin
      resolve(1'b0, 32'h0);
      chk("fifo_order_idx", 64'(upd_index), 64'(5 + i));
    end

    // Errors: empty queue, and resolve during recovery
    resolve(1'b1, 32'h0);
    chk("empty_res_error", 64'(res_error), 64'h1);
    push(32'h3000, 1'b0, 32'h0);
    resolve(1'b1, 32'h3100);
    resolve(1'b1, 32'h3100);
    chk("rec_res_error", 64'(res_error), 64'h1);
    chk("rec_no_upd", 64'(upd_valid), 64'h0);
    idle(); idle();

    // Reset during recovery
    push(32'h3000, 1'b0, 32'h0);
    resolve(1'b1, 32'h3100);
    chk("pre_rst_redirect", 64'(redirect_pc), 64'h3100);
    do_reset();
    idle(); idle(); idle();

    // PC wrap on not-taken redirect
    push(32'hFFFF_FFFC, 1'b1, 32'h10);
    resolve(1'b0, 32'h0);
    chk("wrap_redirect", 64'(redirect_pc), 64'h0);
    idle(); idle();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      logic        pv, pt, rv, rt;
      logic [31:0] pc, ptg, rtg;
      if ($urandom_range(0, 149) == 0) do_reset();
      pv  = 1'($urandom_range(0, 1));
      pc  = $urandom & 32'hFFFF_FFFC;
      pt  = 1'($urandom_range(0, 1));
      ptg = ($urandom_range(0, 1) != 0) ? 32'h400 : 32'h800;
      rv  = ($urandom_range(0, 2) == 0);
      rt  = 1'($urandom_range(0, 1));
      rtg = ($urandom_range(0, 1) != 0) ? 32'h400 : 32'h800;
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
        rt  = mq[0].taken;
        rtg = mq[0].target;
      end
      cycle(pv, pc, pt, ptg, rv, rt, rtg);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Sequences the pipeline's branch-prediction loop.
- Records each fetch-stage prediction in an in-order in-flight queue and compares it against the execute-stage resolution.
- On a mispredict, issues a flush and redirect PC and holds fetch for a recovery window.
- Drives the update port of the 2-bit pattern history table for every resolved branch, and keeps branch and mispredict statistics.

Parameters:
- DEPTH, 4, in-flight prediction queue entries; must be a power of two, ≥2.
- IDX_W, 6, PHT index width; index is pred_pc[IDX_W+1:2].
- RECOVER_CYC, 2, cycles fetch is held after a flush; must be ≥1.
- CNT_W, 32, statistics counter width.

Ports:
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- pred_valid  in  1  fetch issues a branch prediction this cycle
- pred_ready  out  1  queue can accept a prediction
- pred_pc  in  32  PC of predicted branch
- pred_taken  in  1  predicted direction from PHT
- pred_target  in  32  predicted target
- res_valid  in  1  execute resolves oldest in-flight branch
- res_taken  in  1  actual direction
- res_target  in  32  actual target
- flush  out  1  one-cycle pulse: squash younger instructions
- redirect_pc  out  32  fetch PC to restart from; valid when flush=1
- upd_valid  out  1  one-cycle PHT update strobe
- upd_index  out  IDX_W  PHT entry to update
- upd_taken  out  1  actual outcome for PHT update
- res_error  out  1  one-cycle pulse: res_valid with empty queue or during RECOVER
- inflight_count  out  $clog2(DEPTH)+1  queue occupancy
- branch_count  out  CNT_W  resolved branches, saturating
- mispred_count  out  CNT_W  mispredicts, saturating

Behaviour:
- Reset values (next edge with reset=1):
  - FSM=RUN; queue empty.
  - flush, upd_valid, upd_taken, res_error = 0.
  - redirect_pc, upd_index = 0; both counters = 0.
  - pred_ready=1 after reset.
  - Reset mid-recovery aborts recovery immediately.
- Queue:
  - Circular FIFO with wrapping rd/wr pointers.
  - Each entry stores {pc, taken, target}.
  - Push when pred_valid && pred_ready; pop when res_valid in RUN with queue non-empty.
  - Push and pop in the same cycle are allowed at any occupancy, including full.
  - Occupancy is unchanged in that case.
- pred_ready = (FSM==RUN) && (count<DEPTH || pop this cycle).
- Mispredict, evaluated on the popped head entry:
  - Direction mismatch: head.taken != res_taken, or
  - Target mismatch: head.taken && res_taken && head.target != res_target.
- Correct target on mispredict: res_target if res_taken, else head.pc+4 (32-bit wrap).
- Latency: resolution in cycle N. In cycle N+1, these are registered outputs:
  - upd_valid=1, upd_index=head.pc[IDX_W+1:2], upd_taken=res_taken.
  - branch_count incremented.
  - On mispredict only: flush=1, redirect_pc=correct target, mispred_count incremented.
- Counters saturate at all-ones and never wrap.
- FSM:
  - RUN→RECOVER on a mispredict pop (transition at the N→N+1 edge).
  - RECOVER holds for RECOVER_CYC cycles via a down-counter, then →RUN.
  - In RECOVER: pred_ready=0; queue is cleared at entry (all younger predictions discarded).
  - res_valid in RECOVER is ignored and pulses res_error.
- Simultaneous events:
  - A mispredict pop and a push in the same cycle: the push is accepted by the handshake but discarded by the clear. Fetch re-issues after redirect.
  - A correct pop and a push in the same cycle are both honoured.
- res_valid with an empty queue in RUN: no pop, no update, res_error=1 next cycle.
- flush, upd_valid and res_error are single-cycle pulses, 0 otherwise.

Decomposition:
- Package branch_pkg holds:
  - ctrl_state_t enum {RUN, RECOVER}.
  - pred_entry_t struct {pc, taken, target}.
  - PC_W=32 constant.
- One sub-module, branch_inflight_fifo: parameterised DEPTH, push/pop/clear, count, head output.
- Controller FSM, compare logic and counters stay in the top module.

Test Plan:
- Correct prediction: push {pc=0x100, taken=1, target=0x200}, resolve taken/0x200 → next cycle upd_valid=1, upd_index=0x00 (pc[7:2]=0x100>>2 → 0x40 masked to 6 bits), upd_taken=1, flush=0, branch_count=1.
- Direction mispredict: push {pc=0x1004, taken=1}, resolve not-taken → flush=1, redirect_pc=0x1008, mispred_count=1. pred_ready=0 for 2 cycles, then 1. Queue count=0.
- Target mispredict: push {taken=1, target=0x300}, resolve taken/0x340 → flush=1, redirect_pc=0x340, upd_taken=1.
- Full queue: push 4 entries → pred_ready=0 with count=4. Push and resolve in the same cycle → accepted, count stays 4. Entries resolve in FIFO order (verify pc order in upd_index).
- Error and recovery: res_valid with empty queue → res_error pulse, counters unchanged. res_valid during RECOVER → res_error, no upd_valid.
- Reset during RECOVER: assert reset one cycle → pred_ready=1, count=0, counters=0, no flush afterwards. Also pc=0xFFFFFFFC mispredicted not-taken → redirect_pc=0x00000000.
